round_controller: RTL and testbench

Match/round sequencer for the singleplayer and versus fighter FSMs. It watches both fighters' state codes and x positions, resolves hits during attack ACTIVE phases, and keeps per-player health and round wins. It gates fighter motion with an enable, re-spawns fighters between rounds, and declares the match winner. It sits between the fighter FSM block and the VGA/HUD renderer, on the same frame-rate clock.

---
 rtl/game_pkg.sv | 33 +++
 rtl/round_controller_if.sv | 32 +++
 rtl/hit_detector.sv | 53 +++++
 rtl/round_controller.sv | 180 ++++++++++++++++++
 tb/tb_round_controller.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the fighter game: fighter state codes, round states
// and playfield geometry.
package game_pkg;

   typedef enum logic [3:0] {
      F_IDLE         = 4'd0,
      F_LEFT         = 4'd1,
      F_RIGHT        = 4'd2,
      F_ATK1_START   = 4'd3,
      F_ATK1_ACTIVE  = 4'd4,
      F_ATK1_RECOVER = 4'd5,
      F_ATK2_START   = 4'd6,
      F_ATK2_ACTIVE  = 4'd7,
      F_ATK2_RECOVER = 4'd8,
      F_HURT         = 4'd9,
      F_BLOCK        = 4'd10
   } fighter_state_e;

   typedef enum logic [2:0] {
      RS_WAIT_START = 3'd0,
      RS_COUNTDOWN  = 3'd1,
      RS_FIGHT      = 3'd2,
      RS_HITSTOP    = 3'd3,
      RS_ROUND_END  = 3'd4,
      RS_MATCH_END  = 3'd5
   } round_state_e;

   localparam int CHAR_WIDTH   = 128;
   localparam int SCREEN_WIDTH = 640;
   localparam int ATK1_REACH   = 32;
   localparam int ATK2_REACH   = 48;

endpackage

// File: rtl/round_controller_if.sv
// Fighter-side inputs and HUD-side outputs of the round controller.
// The controller owns the master modport; fighters/renderer sit on slave.
interface round_controller_if #(
   parameter int HEALTH_W = 2
);
   logic                start_button;
   logic [3:0]          state_p1;
   logic [3:0]          state_p2;
   logic [9:0]          char1_x;
   logic [9:0]          char2_x;
   logic                fighter_en;
   logic                fighter_rst;
   logic [2:0]          round_state;
   logic [HEALTH_W-1:0] health_p1;
   logic [HEALTH_W-1:0] health_p2;
   logic [1:0]          wins_p1;
   logic [1:0]          wins_p2;
   logic [1:0]          match_winner;
   logic                hit_flash;

   modport master (
      input  start_button, state_p1, state_p2, char1_x, char2_x,
      output fighter_en, fighter_rst, round_state, health_p1, health_p2,
             wins_p1, wins_p2, match_winner, hit_flash
   );

   modport slave (
      output start_button, state_p1, state_p2, char1_x, char2_x,
      input  fighter_en, fighter_rst, round_state, health_p1, health_p2,
             wins_p1, wins_p2, match_winner, hit_flash
   );
endinterface

// File: rtl/hit_detector.sv
// Flags a landed hit on either fighter: attack ACTIVE entry edge, reach
// check in 12-bit unsigned arithmetic, and retreat-blocking by the defender.
module hit_detector #(
   parameter int CHAR_WIDTH = game_pkg::CHAR_WIDTH,
   parameter int ATK1_REACH = game_pkg::ATK1_REACH,
   parameter int ATK2_REACH = game_pkg::ATK2_REACH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] state_p1,
   input  logic [3:0] state_p2,
   input  logic [9:0] char1_x,
   input  logic [9:0] char2_x,
   output logic       hit_on_p1,
   output logic       hit_on_p2
);
   import game_pkg::*;

   logic [3:0] prev_p1_q;
   logic [3:0] prev_p2_q;
   logic       p1_edge;
   logic       p2_edge;

   function automatic logic is_active(input logic [3:0] st);
      return (st == F_ATK1_ACTIVE) || (st == F_ATK2_ACTIVE);
   endfunction

   // Right edge of p1's sprite plus the reach of the given attack.
   function automatic logic [11:0] strike_edge(input logic [9:0] x, input logic [3:0] st);
      return {2'b00, x} + 12'(CHAR_WIDTH)
             + ((st == F_ATK2_ACTIVE) ? 12'(ATK2_REACH) : 12'(ATK1_REACH));
   endfunction

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_p1_q <= F_IDLE;
         prev_p2_q <= F_IDLE;
      end else begin
         prev_p1_q <= state_p1;
         prev_p2_q <= state_p2;
      end
   end

   assign p1_edge   = is_active(state_p1) && (prev_p1_q != state_p1);
   assign p2_edge   = is_active(state_p2) && (prev_p2_q != state_p2);

   assign hit_on_p2 = p1_edge && (strike_edge(char1_x, state_p1) >= {2'b00, char2_x})
                      && (state_p2 != F_RIGHT);
   assign hit_on_p1 = p2_edge && ({2'b00, char2_x} <= strike_edge(char1_x, state_p2))
                      && (state_p1 != F_LEFT);

endmodule

// File: rtl/round_controller.sv
// Match/round sequencer: health, round wins, fighter enable/respawn, winner.
// Define ROUND_TIMER_EN to add a per-round time limit decided on health.
module round_controller #(
   parameter int MAX_HEALTH       = 3,
   parameter int WINS_NEEDED      = 2,
   parameter int COUNTDOWN_FRAMES = 60,
   parameter int HITSTOP_FRAMES   = 8,
   parameter int END_FRAMES       = 120,
   parameter int CHAR_WIDTH       = game_pkg::CHAR_WIDTH,
   parameter int ATK1_REACH       = game_pkg::ATK1_REACH,
   parameter int ATK2_REACH       = game_pkg::ATK2_REACH
`ifdef ROUND_TIMER_EN
   ,parameter int ROUND_FRAMES    = 3600
`endif
) (
   input logic                clk_game,
   input logic                reset,
   round_controller_if.master bus
);
   import game_pkg::*;

   localparam int HEALTH_W = $clog2(MAX_HEALTH + 1);
   localparam logic [HEALTH_W-1:0] FULL_HEALTH = HEALTH_W'(MAX_HEALTH);

   round_state_e        state_q, state_d;
   logic [11:0]         frame_q, frame_d;
   logic [HEALTH_W-1:0] hp1_q, hp1_d, hp2_q, hp2_d;
   logic [1:0]          wins_p1_q, wins_p1_d, wins_p2_q, wins_p2_d;
   logic [1:0]          winner_q, winner_d;
   logic                en_q, en_d, respawn_q, respawn_d, flash_q, flash_d;
   logic                award;
   logic                hit_on_p1, hit_on_p2;

   hit_detector #(
      .CHAR_WIDTH (CHAR_WIDTH),
      .ATK1_REACH (ATK1_REACH),
      .ATK2_REACH (ATK2_REACH)
   ) u_hit_detector (
      .clk       (clk_game),
      .rst       (reset),
      .state_p1  (bus.state_p1),
      .state_p2  (bus.state_p2),
      .char1_x   (bus.char1_x),
      .char2_x   (bus.char2_x),
      .hit_on_p1 (hit_on_p1),
      .hit_on_p2 (hit_on_p2)
   );

`ifdef ROUND_TIMER_EN
   logic [11:0] round_frames_q, round_frames_d;

   always_comb begin
      round_frames_d = round_frames_q;
      if (state_q == RS_FIGHT)     round_frames_d = round_frames_q + 12'd1;
      if (state_d == RS_COUNTDOWN) round_frames_d = '0;
   end

   always_ff @(posedge clk_game or posedge reset) begin
      if (reset) round_frames_q <= '0;
      else       round_frames_q <= round_frames_d;
   end
`endif

   // NOTE: every variable of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q + 12'd1;
      hp1_d     = hp1_q;
      hp2_d     = hp2_q;
      wins_p1_d = wins_p1_q;
      wins_p2_d = wins_p2_q;
      winner_d  = winner_q;
      respawn_d = 1'b0;
      award     = 1'b0;

      case (state_q)
         RS_WAIT_START, RS_MATCH_END: begin
            if (bus.start_button) begin
               state_d   = RS_COUNTDOWN;
               hp1_d     = FULL_HEALTH;
               hp2_d     = FULL_HEALTH;
               wins_p1_d = '0;
               wins_p2_d = '0;
               winner_d  = 2'b00;
               respawn_d = 1'b1;
            end
         end
         RS_COUNTDOWN: begin
            if (frame_q == 12'(COUNTDOWN_FRAMES - 1)) state_d = RS_FIGHT;
         end
         RS_FIGHT: begin
            if (hit_on_p1 || hit_on_p2) begin
               if (hit_on_p1 && (hp1_q != '0)) hp1_d = hp1_q - 1'b1;
               if (hit_on_p2 && (hp2_q != '0)) hp2_d = hp2_q - 1'b1;
               state_d = RS_HITSTOP;
            end
`ifdef ROUND_TIMER_EN
            else if (round_frames_q >= 12'(ROUND_FRAMES - 1)) begin
               state_d = RS_ROUND_END;
               award   = 1'b1;
            end
`endif
         end
         RS_HITSTOP: begin
            if (frame_q == 12'(HITSTOP_FRAMES - 1)) begin
               if ((hp1_q == '0) || (hp2_q == '0)) begin
                  state_d = RS_ROUND_END;
                  award   = 1'b1;
               end else begin
                  state_d = RS_FIGHT;
               end
            end
         end
         RS_ROUND_END: begin
            if (frame_q == 12'(END_FRAMES - 1)) begin
               if (wins_p1_q == 2'(WINS_NEEDED)) begin
                  winner_d = 2'b01;
                  state_d  = RS_MATCH_END;
               end else if (wins_p2_q == 2'(WINS_NEEDED)) begin
                  winner_d = 2'b10;
                  state_d  = RS_MATCH_END;
               end else begin
                  hp1_d     = FULL_HEALTH;
                  hp2_d     = FULL_HEALTH;
                  respawn_d = 1'b1;
                  state_d   = RS_COUNTDOWN;
               end
            end
         end
         default: state_d = RS_WAIT_START;
      endcase

      // A KO always leaves the survivor ahead, so one rule serves KO and time-out.
      if (award) begin
         if (hp1_q > hp2_q)      wins_p1_d = wins_p1_q + 2'd1;
         else if (hp2_q > hp1_q) wins_p2_d = wins_p2_q + 2'd1;
      end

      if (state_d != state_q) frame_d = '0;
      en_d    = (state_d == RS_FIGHT);
      flash_d = (state_d == RS_HITSTOP);
   end

   always_ff @(posedge clk_game or posedge reset) begin
      if (reset) begin
         state_q   <= RS_WAIT_START;
         frame_q   <= '0;
         hp1_q     <= FULL_HEALTH;
         hp2_q     <= FULL_HEALTH;
         wins_p1_q <= '0;
         wins_p2_q <= '0;
         winner_q  <= 2'b00;
         en_q      <= 1'b0;
         respawn_q <= 1'b0;
         flash_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         hp1_q     <= hp1_d;
         hp2_q     <= hp2_d;
         wins_p1_q <= wins_p1_d;
         wins_p2_q <= wins_p2_d;
         winner_q  <= winner_d;
         en_q      <= en_d;
         respawn_q <= respawn_d;
         flash_q   <= flash_d;
      end
   end

   assign bus.round_state  = state_q;
   assign bus.health_p1    = hp1_q;
   assign bus.health_p2    = hp2_q;
   assign bus.wins_p1      = wins_p1_q;
   assign bus.wins_p2      = wins_p2_q;
   assign bus.match_winner = winner_q;
   assign bus.fighter_en   = en_q;
   assign bus.fighter_rst  = respawn_q;
   assign bus.hit_flash    = flash_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: reset, round start, hits, blocking,
// reach limits, trades, a full match and mid-round reset.
module tb_round_controller;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   round_controller_if bus ();

   round_controller dut (
      .clk_game (clk),
      .reset    (reset),
      .bus      (bus)
   );

   // {round_state, hp1, hp2, wins_p1, wins_p2, winner, en, rst, flash}
   localparam logic [15:0] RESET_SNAP = {3'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 3'b000};

   function automatic logic [15:0] snap();
      return {bus.round_state, bus.health_p1, bus.health_p2, bus.wins_p1, bus.wins_p2,
              bus.match_winner, bus.fighter_en, bus.fighter_rst, bus.hit_flash};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_idle();
      bus.start_button = 1'b0;
      bus.state_p1     = 4'd0;
      bus.state_p2     = 4'd0;
      bus.char1_x      = 10'd300;
      bus.char2_x      = 10'd450;
   endtask

   // Reset, press start, and run the countdown so the next cycle is FIGHT.
   task automatic fresh_round();
      reset = 1'b1;
      drive_idle();
      tick(2);
      reset = 1'b0;
      tick(1);
      bus.start_button = 1'b1;
      tick(1);
      bus.start_button = 1'b0;
      tick(60);
   endtask

   task automatic p1_strike(input logic [3:0] atk);
      bus.state_p1 = atk;
      tick(1);
      bus.state_p1 = 4'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      tick(2);
      total++; if (snap() !== RESET_SNAP) begin bad++; $display("FAIL reset_values: got %h want %h", snap(), RESET_SNAP); end
      reset = 1'b0;
      tick(3);
      total++; if (bus.round_state !== 3'd0) begin bad++; $display("FAIL idle_wait: got %0d want 0", bus.round_state); end
   endtask

   task automatic test_start();
      int pulses;
      bus.start_button = 1'b1;
      tick(1);
      bus.start_button = 1'b0;
      total++; if (bus.round_state !== 3'd1) begin bad++; $display("FAIL start_countdown: got %0d want 1", bus.round_state); end
      total++; if (bus.fighter_rst !== 1'b1) begin bad++; $display("FAIL start_rst_pulse: got %b want 1", bus.fighter_rst); end
      pulses = 0;
      for (int i = 0; i < 59; i++) begin
         tick(1);
         if (bus.fighter_rst === 1'b1) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL rst_single_pulse: got %0d extra want 0", pulses); end
      total++; if (bus.round_state !== 3'd1) begin bad++; $display("FAIL countdown_len59: got %0d want 1", bus.round_state); end
      tick(1);
      total++; if (bus.round_state !== 3'd2) begin bad++; $display("FAIL fight_at60: got %0d want 2", bus.round_state); end
      total++; if (bus.fighter_en !== 1'b1) begin bad++; $display("FAIL fight_en: got %b want 1", bus.fighter_en); end
      bus.start_button = 1'b1;
      tick(5);
      bus.start_button = 1'b0;
      total++; if ({bus.round_state, bus.fighter_rst} !== {3'd2, 1'b0}) begin bad++; $display("FAIL start_ignored: got %0d/%b want 2/0", bus.round_state, bus.fighter_rst); end
   endtask

   task automatic test_p1_hit();
      fresh_round();
      bus.state_p1 = 4'd4;
      tick(1);
      total++; if ({bus.health_p1, bus.health_p2} !== {2'd3, 2'd2}) begin bad++; $display("FAIL hit_health: got %0d/%0d want 3/2", bus.health_p1, bus.health_p2); end
      total++; if ({bus.round_state, bus.fighter_en, bus.hit_flash} !== {3'd3, 1'b0, 1'b1}) begin bad++; $display("FAIL hit_hitstop: got %0d/%b/%b want 3/0/1", bus.round_state, bus.fighter_en, bus.hit_flash); end
      tick(7);
      total++; if (bus.round_state !== 3'd3) begin bad++; $display("FAIL hitstop_len7: got %0d want 3", bus.round_state); end
      tick(1);
      total++; if ({bus.round_state, bus.fighter_en, bus.hit_flash} !== {3'd2, 1'b1, 1'b0}) begin bad++; $display("FAIL hitstop_exit: got %0d/%b/%b want 2/1/0", bus.round_state, bus.fighter_en, bus.hit_flash); end
      tick(2);
      total++; if (bus.health_p2 !== 2'd2) begin bad++; $display("FAIL one_hit_per_active: got %0d want 2", bus.health_p2); end
      bus.state_p1 = 4'd0;
      tick(1);
   endtask

   task automatic test_block();
      fresh_round();
      bus.state_p2 = 4'd2;
      bus.state_p1 = 4'd4;
      tick(1);
      total++; if ({bus.round_state, bus.health_p2} !== {3'd2, 2'd3}) begin bad++; $display("FAIL block_p2_right: got %0d/%0d want 2/3", bus.round_state, bus.health_p2); end
      bus.state_p1 = 4'd1;
      bus.state_p2 = 4'd4;
      tick(1);
      total++; if ({bus.round_state, bus.health_p1} !== {3'd2, 2'd3}) begin bad++; $display("FAIL block_p1_left: got %0d/%0d want 2/3", bus.round_state, bus.health_p1); end
      drive_idle();
      tick(1);
   endtask

   task automatic test_range_boundary();
      fresh_round();
      bus.char2_x = 10'd460;
      p1_strike(4'd4);
      total++; if ({bus.round_state, bus.health_p2} !== {3'd3, 2'd2}) begin bad++; $display("FAIL reach1_exact: got %0d/%0d want 3/2", bus.round_state, bus.health_p2); end
      tick(8);
      bus.char2_x = 10'd461;
      p1_strike(4'd4);
      total++; if ({bus.round_state, bus.health_p2} !== {3'd2, 2'd2}) begin bad++; $display("FAIL reach1_beyond: got %0d/%0d want 2/2", bus.round_state, bus.health_p2); end
      tick(1);
      bus.char2_x = 10'd476;
      p1_strike(4'd7);
      total++; if ({bus.round_state, bus.health_p2} !== {3'd3, 2'd1}) begin bad++; $display("FAIL reach2_exact: got %0d/%0d want 3/1", bus.round_state, bus.health_p2); end
      tick(8);
      drive_idle();
   endtask

   task automatic test_trade();
      fresh_round();
      bus.state_p1 = 4'd7;
      bus.state_p2 = 4'd7;
      tick(1);
      total++; if ({bus.round_state, bus.health_p1, bus.health_p2} !== {3'd3, 2'd2, 2'd2}) begin bad++; $display("FAIL trade: got %0d/%0d/%0d want 3/2/2", bus.round_state, bus.health_p1, bus.health_p2); end
      drive_idle();
      tick(8);
   endtask

   task automatic ko_p2();
      for (int h = 0; h < 3; h++) begin
         p1_strike(4'd4);
         tick(8);
      end
   endtask

   task automatic test_match();
      fresh_round();
      ko_p2();
      total++; if ({bus.round_state, bus.health_p2, bus.wins_p1, bus.fighter_en} !== {3'd4, 2'd0, 2'd1, 1'b0}) begin bad++; $display("FAIL round1_end: got %0d/%0d/%0d/%b want 4/0/1/0", bus.round_state, bus.health_p2, bus.wins_p1, bus.fighter_en); end
      tick(119);
      total++; if (bus.round_state !== 3'd4) begin bad++; $display("FAIL round_end_len119: got %0d want 4", bus.round_state); end
      tick(1);
      total++; if (snap() !== {3'd1, 2'd3, 2'd3, 2'd1, 2'd0, 2'd0, 3'b010}) begin bad++; $display("FAIL round2_respawn: got %h want %h", snap(), {3'd1, 2'd3, 2'd3, 2'd1, 2'd0, 2'd0, 3'b010}); end
      tick(60);
      ko_p2();
      total++; if (bus.wins_p1 !== 2'd2) begin bad++; $display("FAIL round2_win: got %0d want 2", bus.wins_p1); end
      tick(120);
      total++; if ({bus.round_state, bus.match_winner} !== {3'd5, 2'b01}) begin bad++; $display("FAIL match_end: got %0d/%b want 5/01", bus.round_state, bus.match_winner); end
      tick(5);
      total++; if (bus.round_state !== 3'd5) begin bad++; $display("FAIL match_hold: got %0d want 5", bus.round_state); end
      bus.start_button = 1'b1;
      tick(1);
      bus.start_button = 1'b0;
      total++; if (snap() !== {3'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 3'b010}) begin bad++; $display("FAIL restart: got %h want %h", snap(), {3'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 3'b010}); end
   endtask

   task automatic test_reset_mid();
      fresh_round();
      p1_strike(4'd4);
      tick(11);
      #2 reset = 1'b1;
      #1;
      total++; if (snap() !== RESET_SNAP) begin bad++; $display("FAIL reset_mid_fight: got %h want %h", snap(), RESET_SNAP); end
      tick(1);
      reset = 1'b0;
      fresh_round();
      p1_strike(4'd4);
      tick(8);
      p1_strike(4'd4);
      tick(8);
      p1_strike(4'd4);
      tick(3);
      reset = 1'b1;
      #1;
      total++; if (snap() !== RESET_SNAP) begin bad++; $display("FAIL reset_mid_ko: got %h want %h", snap(), RESET_SNAP); end
      tick(2);
      reset = 1'b0;
      tick(10);
      total++; if ({bus.round_state, bus.wins_p1} !== {3'd0, 2'd0}) begin bad++; $display("FAIL reset_no_win: got %0d/%0d want 0/0", bus.round_state, bus.wins_p1); end
   endtask

`ifdef ROUND_TIMER_EN
   task automatic test_timer();
      fresh_round();
      p1_strike(4'd4);
      tick(8);
      tick(3598);
      total++; if (bus.round_state !== 3'd2) begin bad++; $display("FAIL timer_not_yet: got %0d want 2", bus.round_state); end
      tick(1);
      total++; if ({bus.round_state, bus.wins_p1, bus.wins_p2} !== {3'd4, 2'd1, 2'd0}) begin bad++; $display("FAIL timer_3v2: got %0d/%0d/%0d want 4/1/0", bus.round_state, bus.wins_p1, bus.wins_p2); end
      fresh_round();
      bus.state_p1 = 4'd4;
      bus.state_p2 = 4'd4;
      tick(1);
      drive_idle();
      tick(8);
      tick(3599);
      total++; if ({bus.round_state, bus.wins_p1, bus.wins_p2} !== {3'd4, 2'd0, 2'd0}) begin bad++; $display("FAIL timer_2v2: got %0d/%0d/%0d want 4/0/0", bus.round_state, bus.wins_p1, bus.wins_p2); end
   endtask
`endif

   initial begin
      test_reset();
      test_start();
      test_p1_hit();
      test_block();
      test_range_boundary();
      test_trade();
      test_match();
      test_reset_mid();
`ifdef ROUND_TIMER_EN
      test_timer();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
